// File: rtl/psum_pkg.sv
// Shared widths and FSM encoding for the partial-sum packing/unpacking pair.
package psum_pkg;
  localparam int DW    = 16;
  localparam int LANES = 4;
  localparam int PKD_W = DW * LANES;
  localparam int IDX_W = $clog2(LANES);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;
endpackage

// File: rtl/psum_lane_sel.sv
// Lane select mux: lane 0 sits in the most significant DW bits of the hold word.
module psum_lane_sel
  import psum_pkg::*;
#(
  parameter int DW    = psum_pkg::DW,
  parameter int LANES = psum_pkg::LANES,
  parameter int IDX_W = $clog2(LANES)
) (
  input  logic [DW*LANES-1:0] hold,
  input  logic [IDX_W-1:0]    idx,
  output logic [DW-1:0]       dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < LANES; i++) begin
      if (idx == IDX_W'(i)) begin
        dout = hold[DW*LANES-1-DW*i -: DW];
      end else begin
        dout = dout;
      end
    end
  end

endmodule

// File: rtl/psum_unpack.sv
// Splits a packed DW*LANES word into DW-wide lanes, lane 0 first, with valid/ready on both sides.
// Optional output dout_last is enabled by defining PSUM_UNPACK_LAST_EN.
module psum_unpack
  import psum_pkg::*;
#(
  parameter int DW    = psum_pkg::DW,
  parameter int LANES = psum_pkg::LANES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pkd_valid,
  output logic                       pkd_ready,
  input  logic [DW*LANES-1:0]        psum_pkd,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [DW-1:0]              dout,
  output logic [$clog2(LANES)-1:0]   dout_idx,
`ifdef PSUM_UNPACK_LAST_EN
  output logic                       dout_last,
`endif
  output logic                       busy
);

  localparam int HW = DW * LANES;
  localparam int IW = $clog2(LANES);
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          last_lane;
  logic          xfer;

  assign last_lane = (idx_q == LAST_IDX);
  // A new word is only taken while idle or on the beat that drains the final lane.
  assign pkd_ready = (state_q == IDLE) ? 1'b1 : (last_lane && dout_ready);
  assign xfer      = pkd_valid && pkd_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          hold_d  = psum_pkd;
          idx_d   = '0;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (dout_ready && last_lane) begin
          idx_d = '0;
          if (xfer) begin
            hold_d  = psum_pkd;
            state_d = SEND;
          end else begin
            state_d = IDLE;
          end
        end else if (dout_ready) begin
          idx_d = idx_q + IW'(1);
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  psum_lane_sel #(
    .DW    (DW),
    .LANES (LANES),
    .IDX_W (IW)
  ) u_lane_sel (
    .hold (hold_q),
    .idx  (idx_q),
    .dout (dout)
  );

  assign dout_valid = (state_q == SEND);
  assign dout_idx   = idx_q;
  assign busy       = (state_q == SEND);
`ifdef PSUM_UNPACK_LAST_EN
  assign dout_last  = (state_q == SEND) && last_lane;
`endif

endmodule

// File: tb/tb_psum_unpack.sv
// Directed testbench for psum_unpack: single word, back-to-back, backpressure, reset and round trip.
module tb_psum_unpack;
  logic        clk;
  logic        rst_n;
  logic        pkd_valid;
  logic        pkd_ready;
  logic [63:0] psum_pkd;
  logic        dout_valid;
  logic        dout_ready;
  logic [15:0] dout;
  logic [1:0]  dout_idx;
  logic        busy;
`ifdef PSUM_UNPACK_LAST_EN
  logic        dout_last;
`endif

  int n_cmp = 0;
  int n_err = 0;

  psum_unpack dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pkd_valid  (pkd_valid),
    .pkd_ready  (pkd_ready),
    .psum_pkd   (psum_pkd),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_idx   (dout_idx),
`ifdef PSUM_UNPACK_LAST_EN
    .dout_last  (dout_last),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] exp_d, input logic [1:0] exp_i,
                          input logic exp_rdy);
    #1;
    chk({tag, ".valid"}, 64'(dout_valid), 64'd1);
    chk({tag, ".dout"},  64'(dout),       64'(exp_d));
    chk({tag, ".idx"},   64'(dout_idx),   64'(exp_i));
    chk({tag, ".rdy"},   64'(pkd_ready),  64'(exp_rdy));
    chk({tag, ".busy"},  64'(busy),       64'd1);
`ifdef PSUM_UNPACK_LAST_EN
    chk({tag, ".last"},  64'(dout_last),  64'(exp_i == 2'd3));
`endif
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, ".valid"}, 64'(dout_valid), 64'd0);
    chk({tag, ".busy"},  64'(busy),       64'd0);
    chk({tag, ".rdy"},   64'(pkd_ready),  64'd1);
`ifdef PSUM_UNPACK_LAST_EN
    chk({tag, ".last"},  64'(dout_last),  64'd0);
`endif
  endtask

  logic [15:0] t1 [4]  = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
  logic [15:0] t2 [8]  = '{16'h1010, 16'h2020, 16'h3030, 16'h4040,
                           16'h5050, 16'h6060, 16'h7070, 16'h8080};
  logic [15:0] rt [8]  = '{16'hDEAD, 16'hBEEF, 16'h0000, 16'hFFFF,
                           16'h1234, 16'h8001, 16'h7FFE, 16'h0F0F};
  logic        rpat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int n_out;
    int w;
    logic [63:0] rt_word [2];

    rst_n = 1'b0; pkd_valid = 1'b0; dout_ready = 1'b1; psum_pkd = 64'h0;
    step();
    step();
    #1;
    chk("rst.valid", 64'(dout_valid), 64'd0);
    chk("rst.dout",  64'(dout),       64'd0);
    chk("rst.idx",   64'(dout_idx),   64'd0);
    chk("rst.busy",  64'(busy),       64'd0);
    chk("rst.rdy",   64'(pkd_ready),  64'd1);
    rst_n = 1'b1;

    // single word, free-flowing downstream
    psum_pkd = 64'h0001_0002_0003_0004; pkd_valid = 1'b1;
    step();
    pkd_valid = 1'b0; psum_pkd = 64'h0;
    for (int i = 0; i < 4; i++) begin
      chk_beat("single", t1[i], 2'(i), i == 3);
      step();
    end
    chk_idle("single.end");

    // two words back-to-back; second word offered early must wait for lane 3
    psum_pkd = 64'h1010_2020_3030_4040; pkd_valid = 1'b1;
    step();
    psum_pkd = 64'h5050_6060_7070_8080;
    for (int b = 0; b < 8; b++) begin
      if (b == 4) pkd_valid = 1'b0;
      chk_beat("b2b", t2[b], 2'(b % 4), (b % 4) == 3);
      step();
    end
    chk_idle("b2b.end");

    // backpressure at lane 1, with a competing word that must be ignored
    psum_pkd = 64'hAAAA_BBBB_CCCC_DDDD; pkd_valid = 1'b1;
    step();
    pkd_valid = 1'b0;
    chk_beat("bp.l0", 16'hAAAA, 2'd0, 1'b0);
    step();
    dout_ready = 1'b0; pkd_valid = 1'b1; psum_pkd = 64'h9999_9999_9999_9999;
    for (int i = 0; i < 3; i++) begin
      chk_beat("bp.stall", 16'hBBBB, 2'd1, 1'b0);
      step();
    end
    dout_ready = 1'b1; pkd_valid = 1'b0;
    chk_beat("bp.l1", 16'hBBBB, 2'd1, 1'b0);
    step();
    chk_beat("bp.l2", 16'hCCCC, 2'd2, 1'b0);
    step();
    chk_beat("bp.l3", 16'hDDDD, 2'd3, 1'b1);
    step();
    chk_idle("bp.end");

    // reset while lane 2 is on the output
    psum_pkd = 64'hAAAA_BBBB_CCCC_DDDD; pkd_valid = 1'b1;
    step();
    pkd_valid = 1'b0;
    step();
    step();
    chk_beat("mid.l2", 16'hCCCC, 2'd2, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_idle("mid.rst");
    chk("mid.dout", 64'(dout),     64'd0);
    chk("mid.idx",  64'(dout_idx), 64'd0);
    psum_pkd = 64'h1111_2222_3333_4444; pkd_valid = 1'b1;
    step();
    pkd_valid = 1'b0;
    chk_beat("mid.new0", 16'h1111, 2'd0, 1'b0);
    step();
    chk_beat("mid.new1", 16'h2222, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk_idle("mid.end");

    // round trip: bench packs lanes, irregular downstream readiness
    rt_word[0] = {rt[0], rt[1], rt[2], rt[3]};
    rt_word[1] = {rt[4], rt[5], rt[6], rt[7]};
    n_out = 0;
    w = 0;
    for (int cyc = 0; cyc < 60 && n_out < 8; cyc++) begin
      dout_ready = rpat[cyc % 5];
      pkd_valid  = (w < 2);
      psum_pkd   = (w < 2) ? rt_word[w] : 64'h0;
      #1;
      if (dout_valid && dout_ready) begin
        chk("rt.dout", 64'(dout),     64'(rt[n_out]));
        chk("rt.idx",  64'(dout_idx), 64'(n_out % 4));
        n_out++;
      end
      if (pkd_valid && pkd_ready) w++;
      step();
    end
    chk("rt.count", 64'(n_out), 64'd8);
    pkd_valid = 1'b0; dout_ready = 1'b1;
    step();
    chk_idle("rt.end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psum_unpack.md
PSUM_UNPACK -- requirements
Module: psum_unpack

Interface
REQ-001 SHALL have parameter DW, default 16: width of one partial sum.
REQ-002 SHALL have parameter LANES, default 4: partial sums per packed word; packed width = DW*LANES (64).
REQ-003 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port pkd_valid  input  1: packed word on psum_pkd is valid.
REQ-006 SHALL have port pkd_ready  output  1: block accepts psum_pkd this cycle.
REQ-007 SHALL have port psum_pkd  input  64: packed word, lane 0 in [63:48], lane 3 in [15:0].
REQ-008 SHALL have port dout_valid  output  1: dout holds a valid lane.
REQ-009 SHALL have port dout_ready  input  1: downstream accepts dout this cycle.
REQ-010 SHALL have port dout  output  16: current partial sum.
REQ-011 SHALL have port dout_idx  output  2: lane index of dout (0..3).
REQ-012 SHALL have port busy  output  1: a packed word is held and not fully drained.

Function
REQ-013 SHALL implement FSM with two states: IDLE (no word held) and SEND (word held, lanes draining).
REQ-014 SHALL accept a word (transfer) when pkd_valid && pkd_ready at a rising edge.
REQ-015 SHALL drive pkd_ready = 1 in IDLE; in SEND, pkd_ready = (idx==3 && dout_ready), combinational.
REQ-016 SHALL, on transfer, register psum_pkd into a 64-bit hold register, set idx=0, enter SEND; first dout_valid in the next cycle (latency 1).
REQ-017 SHALL drive dout = hold[63-16*idx -: 16], dout_idx = idx, dout_valid = 1 while in SEND.
REQ-018 SHALL advance idx by 1 on each dout_valid && dout_ready beat; idx wraps 3->0.
REQ-019 SHALL, on the lane-3 beat: load next word and stay in SEND with idx=0 if pkd_valid, else enter IDLE; no bubble between words (4 beats per 4 cycles sustained).
REQ-020 SHALL hold dout, dout_idx and hold register stable while dout_valid && !dout_ready.
REQ-021 SHALL ignore pkd_valid whenever pkd_ready is 0; psum_pkd changes then have no effect.
REQ-022 SHALL drive busy = (state==SEND).
REQ-023 SHALL emit lanes strictly in order 0,1,2,3; no lane dropped or duplicated.

Reset
REQ-024 SHALL, when rst_n==0 at a rising edge, enter IDLE, idx=0, hold=0; a word in flight is discarded.
REQ-025 SHALL hold outputs during/after reset at: dout_valid=0, dout=0, dout_idx=0, busy=0, pkd_ready=1 (first cycle after release).

Configuration
REQ-026 SHALL, with macro PSUM_UNPACK_LAST_EN defined, add output dout_last (1 bit) = dout_valid && idx==3, reset value 0.
REQ-027 SHALL, without PSUM_UNPACK_LAST_EN, omit port dout_last; all other behaviour identical.

Structure
REQ-028 SHALL take DW, LANES, PKD_W (=DW*LANES) and the state encoding (IDLE=0, SEND=1) from shared package psum_pkg, also used by the packing block.
REQ-029 SHALL be a single module; lane-select mux MAY be sub-module psum_lane_sel (hold, idx -> dout).

Verification
REQ-030 SHALL cover single word: psum_pkd=64'h0001_0002_0003_0004, dout_ready=1 -> dout 0001,0002,0003,0004 on 4 consecutive cycles, idx 0..3, then IDLE.
REQ-031 SHALL cover back-to-back: two words with pkd_valid held -> 8 consecutive valid beats, pkd_ready high only in lane-3 cycle, no gap.
REQ-032 SHALL cover backpressure: dout_ready=0 for 3 cycles at idx=1 of 64'hAAAA_BBBB_CCCC_DDDD -> dout stays BBBB, idx stays 1, pkd_ready=0.
REQ-033 SHALL cover reset mid-word: rst_n=0 at idx=2 -> next cycle dout_valid=0, busy=0, pkd_ready=1; next word starts at idx 0.
REQ-034 SHALL cover PSUM_UNPACK_LAST_EN: dout_last=1 only on lane-3 beats; build without macro compiles without the port.
REQ-035 SHALL cover round trip: packing block output fed in -> dout sequence equals original din sequence.
